// File: rtl/sdram_pattern_tester_if.sv
// Request/response port between the pattern tester and the SDRAM controller.
// The tester drives requests (master); the controller accepts and returns read data (slave).
interface sdram_pattern_tester_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sdram_pattern_tester.sv
// Self-running SDRAM write/read-back sequencer with hardware compare, error capture
// and a manual single-step dump mode for board displays.
module sdram_pattern_tester #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 1023,
    parameter int ERR_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic                  step,
    sdram_pattern_tester_if.master ctrl,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [DATA_W-1:0]     first_err_data,
    output logic [ADDR_W-1:0]     cur_addr,
    output logic [DATA_W-1:0]     last_rdata
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(END_ADDR);

    localparam logic [1:0] M_INCR = 2'd0;
    localparam logic [1:0] M_WALK = 2'd1;
    localparam logic [1:0] M_INV  = 2'd2;
    localparam logic [1:0] M_DUMP = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE,
        S_DUMP_IDLE,
        S_DUMP_WAIT
    } state_t;

    state_t            state;
    logic [1:0]        run_mode;
    logic [ADDR_W-1:0] next_addr;

    // Address is truncated or zero-extended to the data width before INCR/INV.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] bit_idx;
        bit_idx = a % ADDR_W'(DATA_W);
        case (m)
            M_WALK:  pattern = DATA_W'(1) << bit_idx;
            M_INV:   pattern = ~(DATA_W'(a));
            default: pattern = DATA_W'(a);
        endcase
    endfunction

    assign next_addr = cur_addr + ADDR_W'(1);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign pass      = done && (err_count == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= S_IDLE;
            run_mode       <= M_INCR;
            ctrl.cmd_valid <= 1'b0;
            ctrl.cmd_write <= 1'b0;
            ctrl.cmd_addr  <= '0;
            ctrl.cmd_wdata <= '0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            cur_addr       <= FIRST;
            last_rdata     <= '0;
        end else if (abort) begin
            // Withdraw any pending request; the controller tolerates this.
            state          <= S_IDLE;
            ctrl.cmd_valid <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        run_mode       <= mode;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        done           <= 1'b0;
                        cur_addr       <= FIRST;
                        ctrl.cmd_addr  <= FIRST;
                        if (mode == M_DUMP) begin
                            state <= S_DUMP_IDLE;
                        end else begin
                            state          <= S_WR_REQ;
                            ctrl.cmd_valid <= 1'b1;
                            ctrl.cmd_write <= 1'b1;
                            ctrl.cmd_wdata <= pattern(mode, FIRST);
                        end
                    end
                end

                S_WR_REQ: begin
                    if (ctrl.cmd_ready) begin
                        if (cur_addr == LAST) begin
                            cur_addr       <= FIRST;
                            ctrl.cmd_addr  <= FIRST;
                            ctrl.cmd_write <= 1'b0;
                            state          <= S_RD_REQ;
                        end else begin
                            cur_addr       <= next_addr;
                            ctrl.cmd_addr  <= next_addr;
                            ctrl.cmd_wdata <= pattern(run_mode, next_addr);
                        end
                    end
                end

                S_RD_REQ: begin
                    if (ctrl.cmd_ready) begin
                        ctrl.cmd_valid <= 1'b0;
                        state          <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (ctrl.rd_valid) begin
                        last_rdata <= ctrl.rd_data;
                        if (ctrl.rd_data != pattern(run_mode, cur_addr)) begin
                            if (err_count != '1)
                                err_count <= err_count + ERR_W'(1);
                            // A zero count means no mismatch yet in this run.
                            if (err_count == '0) begin
                                first_err_addr <= cur_addr;
                                first_err_data <= ctrl.rd_data;
                            end
                        end
                        if (cur_addr == LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cur_addr       <= next_addr;
                            ctrl.cmd_addr  <= next_addr;
                            ctrl.cmd_valid <= 1'b1;
                            state          <= S_RD_REQ;
                        end
                    end
                end

                S_DUMP_IDLE: begin
                    if (step) begin
                        ctrl.cmd_valid <= 1'b1;
                        ctrl.cmd_write <= 1'b0;
                        ctrl.cmd_addr  <= cur_addr;
                        state          <= S_DUMP_WAIT;
                    end
                end

                S_DUMP_WAIT: begin
                    // Request phase first, then wait for the single read response.
                    if (ctrl.cmd_valid) begin
                        if (ctrl.cmd_ready)
                            ctrl.cmd_valid <= 1'b0;
                    end else if (ctrl.rd_valid) begin
                        last_rdata <= ctrl.rd_data;
                        cur_addr   <= (cur_addr == LAST) ? FIRST : next_addr;
                        state      <= S_DUMP_IDLE;
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    ctrl.cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
